// File: rtl/pfd_loop_filter.sv
// ============================================================================
// pfd_loop_filter : hysteretic zero-crossing PFD, charge pump, PI loop filter
// Revision 1.0
// ============================================================================
`default_nettype none

module pfd_loop_filter #(
  parameter int HYST     = 64,
  parameter int KI       = 64,
  parameter int KP       = 16,
  parameter int INIT_V   = 512,
  parameter int LOCK_TOL = 4,
  parameter int LOCK_N   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic signed [11:0] ref_clock_real,
  input  logic signed [11:0] fb_clock_real,
  output logic        [9:0]  control_voltage_real,
  output logic               up,
  output logic               dn,
  output logic               locked
);

  localparam int LW = $clog2(LOCK_N + 1);

  localparam logic signed [11:0] HYST_P   = 12'(HYST);
  localparam logic signed [11:0] HYST_N   = 12'(-HYST);
  localparam logic signed [11:0] KP_S     = 12'(KP);
  localparam logic signed [11:0] CV_MAX_S = 12'sd1023;
  localparam logic [17:0]        ACC_MAX  = 18'(1023 * 256);
  localparam logic [17:0]        ACC_INIT = 18'(INIT_V * 256);
  localparam logic [17:0]        KI_W     = 18'(KI);
  localparam logic [9:0]         CV_INIT  = 10'(INIT_V);
  localparam logic [7:0]         TOL_W    = 8'(LOCK_TOL);
  localparam logic [LW-1:0]      LOCK_MAX = LW'(LOCK_N);

  typedef enum logic {XING_LOW = 1'b0, XING_HIGH = 1'b1} xing_t;
  typedef enum logic [1:0] {PFD_IDLE = 2'd0, PFD_UP = 2'd1, PFD_DN = 2'd2} pfd_t;

  xing_t             ref_state, ref_state_next;
  xing_t             fb_state, fb_state_next;
  pfd_t              pfd_state, pfd_next;
  logic              ref_edge, fb_edge, in_phase;
  logic [17:0]       acc, acc_next;
  logic [18:0]       acc_sum;
  logic signed [11:0] cv_wide;
  logic [9:0]        cv_next;
  logic [7:0]        width_cnt, width_next;
  logic [LW-1:0]     lock_cnt, lock_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      ref_state            <= XING_HIGH;
      fb_state             <= XING_HIGH;
      pfd_state            <= PFD_IDLE;
      acc                  <= ACC_INIT;
      control_voltage_real <= CV_INIT;
      width_cnt            <= 8'd0;
      lock_cnt             <= '0;
      up                   <= 1'b0;
      dn                   <= 1'b0;
      locked               <= 1'b0;
    end else begin
      ref_state            <= ref_state_next;
      fb_state             <= fb_state_next;
      pfd_state            <= pfd_next;
      acc                  <= acc_next;
      control_voltage_real <= cv_next;
      width_cnt            <= width_next;
      lock_cnt             <= lock_next;
      up                   <= (pfd_next == PFD_UP);
      dn                   <= (pfd_next == PFD_DN);
      locked               <= (lock_next == LOCK_MAX);
    end
  end

  // Crossing detectors: edge pulse is combinational in the cycle the sample arrives
  always_comb begin
    ref_state_next = ref_state;
    fb_state_next  = fb_state;
    ref_edge       = 1'b0;
    fb_edge        = 1'b0;
    if (ref_state == XING_HIGH) begin
      if (ref_clock_real <= HYST_N) ref_state_next = XING_LOW;
    end else if (ref_clock_real >= HYST_P) begin
      ref_state_next = XING_HIGH;
      ref_edge       = 1'b1;
    end
    if (fb_state == XING_HIGH) begin
      if (fb_clock_real <= HYST_N) fb_state_next = XING_LOW;
    end else if (fb_clock_real >= HYST_P) begin
      fb_state_next = XING_HIGH;
      fb_edge       = 1'b1;
    end
  end

  always_comb begin
    pfd_next = pfd_state;
    if (ref_edge && fb_edge) begin
      pfd_next = PFD_IDLE;
    end else if (ref_edge) begin
      pfd_next = (pfd_state == PFD_DN) ? PFD_IDLE : PFD_UP;
    end else if (fb_edge) begin
      pfd_next = (pfd_state == PFD_UP) ? PFD_IDLE : PFD_DN;
    end
  end

  // Integrator and proportional path both key off the registered PFD state
  always_comb begin
    acc_sum  = {1'b0, acc} + {1'b0, KI_W};
    acc_next = acc;
    case (pfd_state)
      PFD_UP:  acc_next = (acc_sum > {1'b0, ACC_MAX}) ? ACC_MAX : acc_sum[17:0];
      PFD_DN:  acc_next = (acc < KI_W) ? 18'd0 : acc - KI_W;
      default: acc_next = acc;
    endcase

    cv_wide = $signed({2'b00, acc_next[17:8]});
    case (pfd_state)
      PFD_UP:  cv_wide = cv_wide + KP_S;
      PFD_DN:  cv_wide = cv_wide - KP_S;
      default: cv_wide = cv_wide;
    endcase

    if (cv_wide < 12'sd0)         cv_next = 10'd0;
    else if (cv_wide > CV_MAX_S)  cv_next = 10'd1023;
    else                          cv_next = cv_wide[9:0];
  end

  always_comb begin
    width_next = width_cnt;
    if ((pfd_next != pfd_state) && (pfd_next != PFD_IDLE)) begin
      width_next = 8'd0;
    end else if ((pfd_state != PFD_IDLE) && (width_cnt != 8'hFF)) begin
      width_next = width_cnt + 8'd1;
    end

    in_phase  = ((pfd_state == PFD_IDLE) && (width_cnt <= TOL_W)) || fb_edge;
    lock_next = lock_cnt;
    if (ref_edge) begin
      if (!in_phase)                lock_next = '0;
      else if (lock_cnt != LOCK_MAX) lock_next = lock_cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pfd_loop_filter.sv
// Bench for pfd_loop_filter: vector table, directed corner sequences and
// randomized stimulus checked against an arithmetic reference model.
`timescale 1ns/1ps
`default_nettype none

module tb_pfd_loop_filter;

  localparam int HYST     = 64;
  localparam int KI       = 64;
  localparam int KP       = 16;
  localparam int INIT_V   = 512;
  localparam int LOCK_TOL = 4;
  localparam int LOCK_N   = 8;
  localparam int ACC_TOP  = 1023 * 256;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic signed [11:0] ref_in = '0;
  logic signed [11:0] fb_in = '0;
  logic        [9:0]  cv;
  logic               up, dn, locked;

  always #5 clk = ~clk;

  pfd_loop_filter #(
    .HYST(HYST), .KI(KI), .KP(KP), .INIT_V(INIT_V),
    .LOCK_TOL(LOCK_TOL), .LOCK_N(LOCK_N)
  ) dut (
    .clk(clk),
    .reset(reset),
    .ref_clock_real(ref_in),
    .fb_clock_real(fb_in),
    .control_voltage_real(cv),
    .up(up),
    .dn(dn),
    .locked(locked)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: phase is 0 idle, +1 ref leading, -1 fb leading
  bit m_ref_hi, m_fb_hi;
  int m_phase, m_acc, m_cv, m_width, m_lock;
  bit m_locked;

  function automatic int clampi(int v, int lo, int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  task automatic model_reset();
    m_ref_hi = 1; m_fb_hi = 1; m_phase = 0;
    m_acc = INIT_V * 256; m_cv = INIT_V; m_width = 0; m_lock = 0; m_locked = 0;
  endtask

  task automatic model_tick(input int r, input int f);
    bit re, fe, in_ph;
    int nph;
    re = !m_ref_hi && (r >= HYST);
    fe = !m_fb_hi && (f >= HYST);
    if (m_ref_hi && r <= -HYST) m_ref_hi = 0; else if (re) m_ref_hi = 1;
    if (m_fb_hi && f <= -HYST) m_fb_hi = 0; else if (fe) m_fb_hi = 1;

    m_acc = clampi(m_acc + m_phase * KI, 0, ACC_TOP);
    m_cv  = clampi(m_acc / 256 + m_phase * KP, 0, 1023);

    // net phase step: +1 for a lone ref edge, -1 for a lone fb edge
    nph = m_phase + (re ? 1 : 0) - (fe ? 1 : 0);
    if (re && fe) nph = 0;
    nph = clampi(nph, -1, 1);

    if (re) begin
      in_ph  = (m_phase == 0 && m_width <= LOCK_TOL) || fe;
      m_lock = in_ph ? clampi(m_lock + 1, 0, LOCK_N) : 0;
    end
    if (nph != 0 && nph != m_phase) m_width = 0;
    else if (m_phase != 0)          m_width = clampi(m_width + 1, 0, 255);
    m_phase  = nph;
    m_locked = (m_lock == LOCK_N);
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, " cv"},     int'(cv),     m_cv);
    check({tag, " up"},     int'(up),     int'(m_phase == 1));
    check({tag, " dn"},     int'(dn),     int'(m_phase == -1));
    check({tag, " locked"}, int'(locked), int'(m_locked));
  endtask

  task automatic step(input int r, input int f, input bit rst, input string tag);
    ref_in = 12'(r);
    fb_in  = 12'(f);
    reset  = rst;
    @(posedge clk);
    #1;
    if (rst) model_reset(); else model_tick(r, f);
    reset = 1'b0;
    check_model(tag);
  endtask

  typedef struct {
    int r; int f; int up; int dn; int cv; int lk;
  } vec_t;
  vec_t tbl[12];

  initial begin
    tbl[0]  = '{0,    0,    0, 0, 512, 0};
    tbl[1]  = '{-100, -100, 0, 0, 512, 0};
    tbl[2]  = '{10,   -10,  0, 0, 512, 0};
    tbl[3]  = '{100,  -100, 1, 0, 512, 0};
    tbl[4]  = '{100,  -100, 1, 0, 528, 0};
    tbl[5]  = '{100,  100,  0, 0, 528, 0};
    tbl[6]  = '{100,  100,  0, 0, 512, 0};
    tbl[7]  = '{-64,  -63,  0, 0, 512, 0};
    tbl[8]  = '{63,   -64,  0, 0, 512, 0};
    tbl[9]  = '{63,   64,   0, 1, 512, 0};
    tbl[10] = '{64,   64,   0, 0, 496, 0};
    tbl[11] = '{0,    0,    0, 0, 512, 0};

    model_reset();

    // Reset
    step(0, 0, 1, "rst");
    step(0, 0, 1, "rst");
    check("reset cv", int'(cv), 512);
    check("reset up", int'(up), 0);
    check("reset dn", int'(dn), 0);
    check("reset locked", int'(locked), 0);

    // Hysteresis: small swings never register as crossings
    for (int i = 0; i < 100; i++)
      step((i % 2) ? 10 : -10, (i % 2) ? -10 : 10, 0, "hyst");
    check("hyst cv", int'(cv), 512);
    check("hyst up", int'(up), 0);
    check("hyst dn", int'(dn), 0);

    // Vector table
    step(0, 0, 1, "rst");
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].r, tbl[i].f, 0, "tbl");
      check($sformatf("tbl[%0d] up", i), int'(up), tbl[i].up);
      check($sformatf("tbl[%0d] dn", i), int'(dn), tbl[i].dn);
      check($sformatf("tbl[%0d] cv", i), int'(cv), tbl[i].cv);
      check($sformatf("tbl[%0d] locked", i), int'(locked), tbl[i].lk);
    end

    // UP response
    step(0, 0, 1, "rst");
    repeat (3) step(-100, -100, 0, "up_pre");
    step(100, -100, 0, "up_edge");
    check("up asserted", int'(up), 1);
    repeat (39) step(100, -100, 0, "up_hold");
    step(100, 100, 0, "up_fb");
    check("up peak cv", int'(cv), 538);
    check("up released", int'(up), 0);
    repeat (2) step(100, 100, 0, "up_settle");
    check("up settle cv", int'(cv), 522);

    // DN response
    step(0, 0, 1, "rst");
    repeat (3) step(-100, -100, 0, "dn_pre");
    step(-100, 100, 0, "dn_edge");
    check("dn asserted", int'(dn), 1);
    repeat (39) step(-100, 100, 0, "dn_hold");
    step(100, 100, 0, "dn_ref");
    check("dn trough cv", int'(cv), 486);
    check("dn released", int'(dn), 0);
    repeat (2) step(100, 100, 0, "dn_settle");
    check("dn settle cv", int'(cv), 502);

    // Saturation high, then low
    step(0, 0, 1, "rst");
    repeat (3) step(-100, -100, 0, "sat_pre");
    step(100, -100, 0, "sat_up");
    repeat (3000) step(100, -100, 0, "sat_up_hold");
    check("sat up cv", int'(cv), 1023);
    check("sat up up", int'(up), 1);
    repeat (2) step(100, 100, 0, "sat_idle");
    check("sat idle cv", int'(cv), 1023);
    step(-100, -100, 0, "sat_low");
    step(-100, 100, 0, "sat_dn");
    repeat (4200) step(-100, 100, 0, "sat_dn_hold");
    check("sat dn cv", int'(cv), 0);
    check("sat dn dn", int'(dn), 1);
    repeat (2) step(100, 100, 0, "sat_dn_idle");
    check("sat floor cv", int'(cv), 0);

    // Lock acquisition with coincident edges, loss on a wide pulse
    step(0, 0, 1, "rst");
    step(-100, -100, 0, "lock_pre");
    for (int p = 0; p < 8; p++) begin
      step(100, 100, 0, "lock_pair");
      if (p == 6) check("lock after 7", int'(locked), 0);
      if (p == 7) check("lock after 8", int'(locked), 1);
      repeat (2) step(-100, -100, 0, "lock_gap");
    end
    step(100, -100, 0, "lag_ref");
    check("lag still locked", int'(locked), 1);
    repeat (19) step(100, -100, 0, "lag_hold");
    step(100, 100, 0, "lag_fb");
    repeat (2) step(-100, -100, 0, "lag_gap");
    step(100, -100, 0, "lag_ref2");
    check("lock lost", int'(locked), 0);
    check("lag up", int'(up), 1);

    // Reset in the middle of an UP pulse
    step(100, -100, 1, "rst_mid");
    check("mid rst up", int'(up), 0);
    check("mid rst cv", int'(cv), 512);
    check("mid rst locked", int'(locked), 0);

    // Randomized stimulus against the model
    for (int i = 0; i < 3000; i++) begin
      int r, f;
      bit rs;
      r  = int'($urandom_range(0, 400)) - 200;
      f  = int'($urandom_range(0, 400)) - 200;
      rs = ($urandom_range(0, 499) == 0);
      step(r, f, rs, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
